// File: rtl/div_pkg.sv
// Shared types and helpers for the sequential restoring divider.
package div_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } div_state_e;

    localparam int DIV_WIDTH_DEFAULT = 8;

    // All-ones pattern of width w, for callers to truncate to their own operand width.
    function automatic logic [63:0] div_all_ones(input int w);
        return (w >= 64) ? {64{1'b1}} : ((64'd1 << w) - 64'd1);
    endfunction

endpackage

// File: rtl/div_step.sv
// One restoring shift/subtract step on the {A,Qr} pair against divisor B.
module div_step #(
    parameter int WIDTH = 8
) (
    input  logic [WIDTH:0]   a,
    input  logic [WIDTH-1:0] qr,
    input  logic [WIDTH-1:0] b,
    output logic [WIDTH:0]   a_nxt,
    output logic [WIDTH-1:0] qr_nxt
);

    logic [WIDTH:0] shifted;
    logic [WIDTH:0] trial;

    // A stays below B, so its top bit is always zero and can be shifted out.
    assign shifted = {a[WIDTH-1:0], qr[WIDTH-1]};
    assign trial   = shifted - {1'b0, b};

    always_comb begin
        a_nxt  = shifted;
        qr_nxt = {qr[WIDTH-2:0], 1'b0};
        if (!trial[WIDTH]) begin
            a_nxt  = trial;
            qr_nxt = {qr[WIDTH-2:0], 1'b1};
        end
    end

endmodule

// File: rtl/div_seq_ctrl.sv
// Multi-cycle unsigned restoring divider sequencer with valid/ready on both sides.
// Define DIV_BYZERO_EN to short-circuit a zero divisor straight to DONE with div_by_zero set.
module div_seq_ctrl
    import div_pkg::*;
#(
    parameter  int WIDTH = DIV_WIDTH_DEFAULT,
    localparam int CNT_W = $clog2(WIDTH) + 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] quotient,
    output logic [WIDTH-1:0] remainder,
    output logic             div_by_zero,
    output logic             busy
);

    div_state_e       state_q, state_d;
    logic [CNT_W-1:0] cnt_q;
    logic [WIDTH:0]   a_q, a_step;
    logic [WIDTH-1:0] qr_q, qr_step, b_q;
    logic [WIDTH-1:0] quotient_q, remainder_q;
    logic             out_valid_q;
    logic             accept, step, last_step, release_out, zero_div;

    div_step #(.WIDTH(WIDTH)) u_step (
        .a      (a_q),
        .qr     (qr_q),
        .b      (b_q),
        .a_nxt  (a_step),
        .qr_nxt (qr_step)
    );

`ifdef DIV_BYZERO_EN
    assign zero_div = (divisor == '0);
`else
    assign zero_div = 1'b0;
`endif

    // NOTE: every signal driven here gets a default first so no path can infer a latch.
    always_comb begin
        state_d     = state_q;
        accept      = 1'b0;
        step        = 1'b0;
        last_step   = 1'b0;
        release_out = 1'b0;
        case (state_q)
            IDLE: begin
                if (in_valid) begin
                    accept  = 1'b1;
                    state_d = zero_div ? DONE : RUN;
                end
            end
            RUN: begin
                step = 1'b1;
                if (cnt_q == CNT_W'(WIDTH - 1)) begin
                    last_step = 1'b1;
                    state_d   = DONE;
                end
            end
            DONE: begin
                if (out_ready) begin
                    release_out = 1'b1;
                    state_d     = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // NOTE: state is updated with non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) state_q <= IDLE;
        else     state_q <= state_d;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q       <= '0;
            a_q         <= '0;
            qr_q        <= '0;
            b_q         <= '0;
            quotient_q  <= '0;
            remainder_q <= '0;
            out_valid_q <= 1'b0;
        end else begin
            if (accept) begin
                b_q   <= divisor;
                a_q   <= '0;
                qr_q  <= dividend;
                cnt_q <= '0;
                if (zero_div) begin
                    quotient_q  <= WIDTH'(div_all_ones(WIDTH));
                    remainder_q <= dividend;
                    out_valid_q <= 1'b1;
                end
            end
            if (step) begin
                a_q   <= a_step;
                qr_q  <= qr_step;
                cnt_q <= cnt_q + 1'b1;
            end
            if (last_step) begin
                quotient_q  <= qr_step;
                remainder_q <= a_step[WIDTH-1:0];
                out_valid_q <= 1'b1;
            end
            if (release_out) out_valid_q <= 1'b0;
        end
    end

`ifdef DIV_BYZERO_EN
    logic dbz_q;

    always_ff @(posedge clk) begin
        if (rst)         dbz_q <= 1'b0;
        else if (accept) dbz_q <= zero_div;
    end

    assign div_by_zero = dbz_q;
`else
    assign div_by_zero = 1'b0;
`endif

    assign in_ready  = (state_q == IDLE);
    assign busy      = (state_q != IDLE);
    assign out_valid = out_valid_q;
    assign quotient  = quotient_q;
    assign remainder = remainder_q;

endmodule
